// File: rtl/mult_iter_if.sv
// Valid/ready bundle between the iterative multiplier and its
// producer (operands) and consumer (product).
interface mult_iter_if #(
    parameter int M = 26,
    parameter int N = 14
);
    logic           in_valid;
    logic           in_ready;
    logic           signed_mode;
    logic [M-1:0]   multi1;
    logic [N-1:0]   multi2;
    logic           out_valid;
    logic           out_ready;
    logic [M+N-1:0] product;
    logic           busy;

    modport master (
        output in_valid, signed_mode, multi1, multi2, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, signed_mode, multi1, multi2, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/mult_iter.sv
// Iterative M x N multiplier retiring K multiplier bits per cycle,
// unsigned or two's-complement per operation.
module mult_iter #(
    parameter int M = 26,
    parameter int N = 14,
    parameter int K = 2
) (
    input  logic       clk,
    input  logic       rst,
    mult_iter_if.slave bus
);
    localparam int C  = (N + K - 1) / K;
    localparam int W  = M + N;
    localparam int PW = C * K;
    localparam int CW = (C > 1) ? $clog2(C) : 1;
    localparam logic [W-1:0]  MC_HI = ~W'({M{1'b1}});
    localparam logic [PW-1:0] MP_HI = ~PW'({N{1'b1}});

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [W-1:0]   r_mcand;
    logic [W-1:0]   r_acc;
    logic [W-1:0]   r_product;
    logic [PW-1:0]  r_mplr;
    logic           r_signed;
    logic [CW-1:0]  r_cnt;

    logic           w_in_ready;
    logic           w_out_valid;
    logic           w_busy;
    logic           w_accept;
    logic           w_last;
    logic           w_neg;
    logic [K-1:0]   w_dig;
    logic [W-1:0]   w_term;
    logic [W-1:0]   w_sum;

    assign w_accept = (r_state == S_IDLE) & bus.in_valid;
    assign w_last   = (r_cnt == CW'(C - 1));
    assign w_dig    = r_mplr[K-1:0];
    // Top digit of a signed multiplier carries weight -2^(K-1).
    assign w_neg    = r_signed & w_last & w_dig[K-1];
    assign w_term   = (r_mcand * W'(w_dig))
                    - (w_neg ? (r_mcand << K) : '0);
    assign w_sum    = r_acc + w_term;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_next = S_CALC;
                end
            end
            S_CALC: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand   <= '0;
            r_acc     <= '0;
            r_product <= '0;
            r_mplr    <= '0;
            r_signed  <= 1'b0;
            r_cnt     <= '0;
        end else if (w_accept) begin
            r_mcand  <= W'(bus.multi1)
                      | ((bus.signed_mode & bus.multi1[M-1]) ? MC_HI : '0);
            r_mplr   <= PW'(bus.multi2)
                      | ((bus.signed_mode & bus.multi2[N-1]) ? MP_HI : '0);
            r_signed <= bus.signed_mode;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == S_CALC) begin
            // Multiplicand pre-shifted so each digit lands at weight K*i.
            r_acc   <= w_sum;
            r_mcand <= r_mcand << K;
            r_mplr  <= r_mplr >> K;
            r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
            if (w_last) begin
                r_product <= w_sum;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.product   = r_product;
endmodule
